// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register between fetch and decode.
// Carries PC, instruction and a sideband field with a valid/ready handshake.
// Flush squashes held and incoming beats, injects NOP_INSN, and adds the
// discarded beats to a saturating flush_drops counter.
//
// Optional feature macro: IF_ID_SKID_EN
//   defined   -> 2-entry skid buffer, registered in_ready, occupancy 0..2
//   undefined -> single register, in_ready = !out_valid || out_ready
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   in_valid/in_ready     fetch-side handshake
//   in_pc/in_insn/in_meta fetch payload
//   flush                 synchronous squash (priority over accept/deliver)
//   out_valid/out_ready   decode-side handshake
//   pc_out/insn_out/meta_out  held payload (empty values when out_valid=0)
//   occupancy             held beat count
//   flush_drops           saturating count of beats discarded by flush
module if_id_stage #(
    parameter int unsigned         PC_W     = 32,
    parameter int unsigned         INSN_W   = 32,
    parameter int unsigned         META_W   = 2,
    parameter logic [INSN_W-1:0]   NOP_INSN = INSN_W'(32'h0000_0013),
    parameter int unsigned         CNT_W    = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INSN_W-1:0] in_insn,
    input  logic [META_W-1:0] in_meta,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc_out,
    output logic [INSN_W-1:0] insn_out,
    output logic [META_W-1:0] meta_out,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_drops
);

    localparam int unsigned SUM_W = CNT_W + 1;

    // State encoding equals the number of held beats.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSN_W-1:0]   insn_q, insn_d;
    logic [META_W-1:0]   meta_q, meta_d;
    logic [CNT_W-1:0]    drops_q, drops_d;

    logic                accept_c;
    logic                deliver_c;
    logic [1:0]          held_c;
    logic [1:0]          drop_c;
    logic [SUM_W-1:0]    drop_sum_c;

`ifdef IF_ID_SKID_EN
    logic                in_ready_q, in_ready_d;
    logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
    logic [INSN_W-1:0]   skid_insn_q, skid_insn_d;
    logic [META_W-1:0]   skid_meta_q, skid_meta_d;

    assign in_ready = in_ready_q;
`else
    // Legacy write-enable behaviour: load whenever the output slot frees up.
    assign in_ready = !valid_q || out_ready;
`endif

    assign accept_c  = in_valid && in_ready;
    assign deliver_c = valid_q && out_ready;

    // Next-state, payload movement and flush accounting.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        meta_d  = meta_q;
        drops_d = drops_q;
`ifdef IF_ID_SKID_EN
        skid_pc_d   = skid_pc_q;
        skid_insn_d = skid_insn_q;
        skid_meta_d = skid_meta_q;
        held_c      = 2'(state_q);

        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    state_d = FULL1;
                    pc_d    = in_pc;
                    insn_d  = in_insn;
                    meta_d  = in_meta;
                end
            end
            FULL1: begin
                if (accept_c && deliver_c) begin
                    pc_d   = in_pc;
                    insn_d = in_insn;
                    meta_d = in_meta;
                end else if (accept_c) begin
                    // Output is stalled: park the new beat in the skid entry.
                    state_d     = FULL2;
                    skid_pc_d   = in_pc;
                    skid_insn_d = in_insn;
                    skid_meta_d = in_meta;
                end else if (deliver_c) begin
                    state_d = EMPTY;
                    pc_d    = '0;
                    insn_d  = NOP_INSN;
                    meta_d  = '0;
                end
            end
            FULL2: begin
                if (deliver_c) begin
                    state_d = FULL1;
                    pc_d    = skid_pc_q;
                    insn_d  = skid_insn_q;
                    meta_d  = skid_meta_q;
                end
            end
            default: state_d = EMPTY;
        endcase
`else
        held_c = {1'b0, (state_q == FULL1)};

        if (accept_c) begin
            state_d = FULL1;
            pc_d    = in_pc;
            insn_d  = in_insn;
            meta_d  = in_meta;
        end else if (deliver_c) begin
            state_d = EMPTY;
            pc_d    = '0;
            insn_d  = NOP_INSN;
            meta_d  = '0;
        end
`endif

        // Held beats plus a same-cycle accepted beat never exceed two.
        drop_c     = held_c + 2'(accept_c);
        drop_sum_c = {1'b0, drops_q} + SUM_W'(drop_c);

        if (flush) begin
            state_d = EMPTY;
            pc_d    = '0;
            insn_d  = NOP_INSN;
            meta_d  = '0;
            drops_d = drop_sum_c[CNT_W] ? {CNT_W{1'b1}} : drop_sum_c[CNT_W-1:0];
        end

        valid_d = (state_d != EMPTY);
`ifdef IF_ID_SKID_EN
        in_ready_d = (state_d != FULL2);
`endif
    end

    // State and payload registers; reset wins over flush.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            pc_q    <= '0;
            insn_q  <= NOP_INSN;
            meta_q  <= '0;
            drops_q <= '0;
`ifdef IF_ID_SKID_EN
            in_ready_q  <= 1'b1;
            skid_pc_q   <= '0;
            skid_insn_q <= NOP_INSN;
            skid_meta_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            meta_q  <= meta_d;
            drops_q <= drops_d;
`ifdef IF_ID_SKID_EN
            in_ready_q  <= in_ready_d;
            skid_pc_q   <= skid_pc_d;
            skid_insn_q <= skid_insn_d;
            skid_meta_q <= skid_meta_d;
`endif
        end
    end

    assign out_valid   = valid_q;
    assign pc_out      = pc_q;
    assign insn_out    = insn_q;
    assign meta_out    = meta_q;
    assign flush_drops = drops_q;
`ifdef IF_ID_SKID_EN
    assign occupancy = 2'(state_q);
`else
    assign occupancy = {1'b0, state_q[0]};
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed, table-driven bench for if_id_stage.
// Expectations for the skid variant are selected with IF_ID_SKID_EN.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_insn;
    logic [1:0]  in_meta;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] insn_out;
    logic [1:0]  meta_out;
    logic [1:0]  occupancy;
    logic [7:0]  flush_drops;

    if_id_stage #(
        .PC_W    (32),
        .INSN_W  (32),
        .META_W  (2),
        .NOP_INSN(32'h0000_0013),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_insn    (in_insn),
        .in_meta    (in_meta),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pc_out     (pc_out),
        .insn_out   (insn_out),
        .meta_out   (meta_out),
        .occupancy  (occupancy),
        .flush_drops(flush_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [1:0]  meta;
        logic        fl;
        logic        ordy;
        logic        e_ir;     // in_ready before the edge
        logic        e_ov;     // outputs after the edge
        logic [31:0] e_pc;
        logic [31:0] e_insn;
        logic [1:0]  e_meta;
        logic [1:0]  e_occ;
        logic [7:0]  e_drops;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic add(input logic iv, input logic [31:0] pc, input logic [31:0] insn,
                       input logic [1:0] meta, input logic fl, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [31:0] e_pc,
                       input logic [31:0] e_insn, input logic [1:0] e_meta,
                       input logic [1:0] e_occ, input logic [7:0] e_drops);
        vec_t v;
        v.iv = iv; v.pc = pc; v.insn = insn; v.meta = meta; v.fl = fl; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_insn = e_insn;
        v.e_meta = e_meta; v.e_occ = e_occ; v.e_drops = e_drops;
        vecs.push_back(v);
    endtask

    // Vector whose post-edge state is the empty stage.
    task automatic add_e(input logic iv, input logic [31:0] pc, input logic fl,
                         input logic ordy, input logic e_ir, input logic [7:0] e_drops);
        add(iv, pc, 32'hDEAD_0000 | pc, 2'd3, fl, ordy, e_ir, 1'b0, 32'h0, NOP, 2'd0, 2'd0, e_drops);
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] insn,
                         input logic [1:0] meta, input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_insn   = insn;
        in_meta   = meta;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic e_ov, input logic [31:0] e_pc,
                             input logic [31:0] e_insn, input logic [1:0] e_meta,
                             input logic [1:0] e_occ, input logic [7:0] e_drops);
        chk({tag, ".out_valid"},   32'(out_valid),   32'(e_ov));
        chk({tag, ".pc_out"},      pc_out,           e_pc);
        chk({tag, ".insn_out"},    insn_out,         e_insn);
        chk({tag, ".meta_out"},    32'(meta_out),    32'(e_meta));
        chk({tag, ".occupancy"},   32'(occupancy),   32'(e_occ));
        chk({tag, ".flush_drops"}, 32'(flush_drops), 32'(e_drops));
    endtask

`ifdef IF_ID_SKID_EN
    localparam logic [7:0] DROPS_AFTER_TABLE = 8'd2;
`else
    localparam logic [7:0] DROPS_AFTER_TABLE = 8'd4;
`endif

    initial begin
        resetn = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 32'h0, NOP, 2'd0, 2'd0, 8'd0);
        resetn = 1'b1;
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // Stream 0x0,0x4,0x8 with out_ready=1, then drain.
        add(1, 32'h0, 32'h0010_0093, 2'd1, 0, 1, 1, 1, 32'h0, 32'h0010_0093, 2'd1, 2'd1, 8'd0);
        add(1, 32'h4, 32'h0020_0113, 2'd2, 0, 1, 1, 1, 32'h4, 32'h0020_0113, 2'd2, 2'd1, 8'd0);
        add(1, 32'h8, 32'h0030_0193, 2'd3, 0, 1, 1, 1, 32'h8, 32'h0030_0193, 2'd3, 2'd1, 8'd0);
        add_e(0, 32'h0, 0, 1, 1, 8'd0);
`ifdef IF_ID_SKID_EN
        // Fill both entries, then drain on consecutive cycles.
        add(1, 32'h100, 32'h1000_0001, 2'd1, 0, 0, 1, 1, 32'h100, 32'h1000_0001, 2'd1, 2'd1, 8'd0);
        add(1, 32'h104, 32'h1040_0002, 2'd2, 0, 0, 1, 1, 32'h100, 32'h1000_0001, 2'd1, 2'd2, 8'd0);
        add(1, 32'h108, 32'h1080_0003, 2'd3, 0, 0, 0, 1, 32'h100, 32'h1000_0001, 2'd1, 2'd2, 8'd0);
        add(1, 32'h108, 32'h1080_0003, 2'd3, 0, 1, 0, 1, 32'h104, 32'h1040_0002, 2'd2, 2'd1, 8'd0);
        add_e(0, 32'h0, 0, 1, 1, 8'd0);
        // FULL2 plus flush with in_valid high.
        add(1, 32'h200, 32'h2000_0001, 2'd1, 0, 0, 1, 1, 32'h200, 32'h2000_0001, 2'd1, 2'd1, 8'd0);
        add(1, 32'h204, 32'h2040_0002, 2'd2, 0, 0, 1, 1, 32'h200, 32'h2000_0001, 2'd1, 2'd2, 8'd0);
        add_e(1, 32'h208, 1, 0, 0, 8'd2);
        add_e(0, 32'h0, 0, 1, 1, 8'd2);
`else
        // Stall: in_ready drops while the held beat waits.
        add(1, 32'h10, 32'h0100_0001, 2'd1, 0, 0, 1, 1, 32'h10, 32'h0100_0001, 2'd1, 2'd1, 8'd0);
        add(1, 32'h14, 32'h0140_0002, 2'd2, 0, 0, 0, 1, 32'h10, 32'h0100_0001, 2'd1, 2'd1, 8'd0);
        // Same-cycle accept and deliver.
        add(1, 32'h14, 32'h0140_0002, 2'd2, 0, 1, 1, 1, 32'h14, 32'h0140_0002, 2'd2, 2'd1, 8'd0);
        // Flush: held + accepted, held only, accepted only.
        add_e(1, 32'h18, 1, 1, 1, 8'd2);
        add(1, 32'h1C, 32'h01C0_0003, 2'd3, 0, 0, 1, 1, 32'h1C, 32'h01C0_0003, 2'd3, 2'd1, 8'd2);
        add_e(0, 32'h0, 1, 0, 0, 8'd3);
        add_e(1, 32'h20, 1, 0, 1, 8'd4);
        add_e(0, 32'h0, 0, 1, 1, 8'd4);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].insn, vecs[i].meta, vecs[i].fl, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            tick();
            check_out($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_insn,
                      vecs[i].e_meta, vecs[i].e_occ, vecs[i].e_drops);
        end

        // Reset while FULL1 and stalled; flush and in_valid in the same cycle are ignored.
        drive(1, 32'h300, 32'h3000_0001, 2'd2, 0, 0);
        tick();
        check_out("prerst", 1'b1, 32'h300, 32'h3000_0001, 2'd2, 2'd1, DROPS_AFTER_TABLE);
        resetn = 1'b0;
        drive(1, 32'h304, 32'h3040_0002, 2'd1, 1, 0);
        tick();
        resetn = 1'b1;
        drive(0, 32'h0, 32'h0, 2'd0, 0, 0);
        check_out("midrst", 1'b0, 32'h0, NOP, 2'd0, 2'd0, 8'd0);
        #1;
        chk("midrst.in_ready", 32'(in_ready), 32'd1);

        // Preload flush_drops to 254 with 127 flushes of two beats each.
        for (int k = 0; k < 127; k++) begin
            drive(1, 32'h400, 32'h4000_0001, 2'd1, 0, 0);
            tick();
            drive(1, 32'h404, 32'h4040_0002, 2'd2, 1, 1);
            tick();
        end
        drive(0, 32'h0, 32'h0, 2'd0, 0, 0);
        check_out("preload", 1'b0, 32'h0, NOP, 2'd0, 2'd0, 8'd254);

`ifdef IF_ID_SKID_EN
        drive(1, 32'h500, 32'h5000_0001, 2'd1, 0, 0);
        tick();
        drive(1, 32'h504, 32'h5040_0002, 2'd2, 0, 0);
        tick();
        chk("sat.occ2", 32'(occupancy), 32'd2);
        drive(0, 32'h0, 32'h0, 2'd0, 1, 0);
        tick();
`else
        drive(1, 32'h500, 32'h5000_0001, 2'd1, 0, 0);
        tick();
        drive(1, 32'h504, 32'h5040_0002, 2'd2, 1, 1);
        tick();
`endif
        check_out("sat", 1'b0, 32'h0, NOP, 2'd0, 2'd0, 8'd255);

        // Another two-beat flush must stay saturated.
        drive(1, 32'h600, 32'h6000_0001, 2'd1, 0, 0);
        tick();
        drive(1, 32'h604, 32'h6040_0002, 2'd2, 1, 1);
        tick();
        drive(0, 32'h0, 32'h0, 2'd0, 0, 0);
        check_out("sat2", 1'b0, 32'h0, NOP, 2'd0, 2'd0, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Parametrised IF/ID pipeline stage for the RV32 core, replacing the fixed 32-bit write-enable/flush register. It carries PC, instruction and a sideband field between fetch and decode using a valid/ready handshake, and supports synchronous flush with NOP injection and a flush-drop counter. An optional 2-entry skid buffer registers the upstream ready so that fetch does not see a combinational path from decode's stall.

## Interface

- PC_W, 32, PC field width
- INSN_W, 32, instruction field width
- META_W, 2, sideband width (e.g. predicted-taken, fetch fault); must be >= 1
- NOP_INSN, 32'h0000_0013, instruction value presented while empty, after reset and after flush
- CNT_W, 8, flush-drop counter width

Ports:

- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch presents a beat
- in_ready  out  1  stage can accept a beat
- in_pc  in  PC_W  fetch PC
- in_insn  in  INSN_W  fetched instruction
- in_meta  in  META_W  fetch sideband
- flush  in  1  synchronous squash of all held and incoming beats
- out_valid  out  1  decode-side beat valid
- out_ready  in  1  decode accepts a beat
- pc_out  out  PC_W  held PC
- insn_out  out  INSN_W  held instruction
- meta_out  out  META_W  held sideband
- occupancy  out  2  number of held beats, 0..2 (0..1 without skid)
- flush_drops  out  CNT_W  saturating count of beats discarded by flush

## Operation

- Accept: in_valid && in_ready at the edge. Deliver: out_valid && out_ready at the edge.
- While out_valid && !out_ready, pc_out, insn_out and meta_out hold stable.
- Empty stage: out_valid=0, pc_out=0, insn_out=NOP_INSN, meta_out=0.
- Beats are delivered in acceptance order. No beat is duplicated or lost except through flush.
- Flush has priority over accept and deliver:
  - At the edge, all held beats are invalidated and outputs return to their empty values.
  - A same-cycle incoming beat is discarded.
- flush_drops increments by (held valid beats + same-cycle accepted beat) on each flush. It saturates at 2^CNT_W-1 and clears only on reset.
- in_valid must not depend combinationally on in_ready. out_ready may depend on out_valid.
- Reset is checked before flush.
- Reset values:
  - out_valid=0, pc_out=0, insn_out=NOP_INSN, meta_out=0
  - occupancy=0, flush_drops=0
  - in_ready=1 from the first cycle after reset
- Reset mid-transfer discards all beats without counting them.

## Timing

- Latency: a beat accepted into an empty stage appears on the outputs the next cycle.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- With skid:
  - States are EMPTY (occ 0), FULL1 (occ 1) and FULL2 (occ 2); in_ready is a registered output.
  - EMPTY→FULL1 on accept.
  - FULL1 stays in FULL1 on accept+deliver or on idle. FULL1→FULL2 on accept with !out_ready; in_ready=0 from the following cycle. FULL1→EMPTY on deliver without accept.
  - FULL2→FULL1 on deliver: the skid entry moves to the output register and in_ready=1 from the following cycle. No accept is possible in FULL2.
  - Any state→EMPTY on flush.
- Without skid: in_ready = !out_valid || out_ready, combinational. States are EMPTY and FULL1 only. This is equivalent to the legacy write-enable behaviour with ifIdWrite = in_ready.

## Configuration

- IF_ID_SKID_EN defined: 2-entry skid buffer, registered in_ready, occupancy up to 2.
- IF_ID_SKID_EN undefined:
  - Single register with combinational in_ready.
  - occupancy[1] is tied to 0.
  - flush_drops increments by at most 2 per flush (held beat + incoming beat).

## Test plan

- Reset, then stream pc 0x0,0x4,0x8 with out_ready=1 → outputs match one cycle after each accept; occupancy stays 1. After the stream, out_valid=0 and insn_out=0x00000013.
- Skid, out_ready=0 while sending 0x100 then 0x104 → occupancy=2 and in_ready=0. Raise out_ready → 0x100 then 0x104 are delivered on consecutive cycles, and in_ready=1 the cycle after the first deliver.
- FULL2 plus flush with a simultaneous in_valid → next cycle out_valid=0, insn_out=0x00000013, occupancy=0, flush_drops=2. The incoming beat is not delivered.
- Preload flush_drops to 254 (CNT_W=8), then flush with 2 held beats → flush_drops=255 (saturated).
- Assert resetn=0 for one cycle while FULL1 with out_ready=0 → all outputs at reset values and flush_drops unchanged from 0 after reset.
- No-skid build, hold out_ready=0 → in_ready is low in the same cycle out_valid=1. Raising out_ready lets a new beat be accepted in the same cycle the old one is delivered.
